// File: rtl/soc_system_pio_in_edge.sv
// Avalon-MM input PIO with two-flop synchroniser, optional per-bit debounce,
// per-bit edge capture (write-1-to-clear) and a maskable level interrupt.
// Register map (word address): 0 DATA, 1 CTRL, 2 IRQMASK, 3 EDGECAP.
module soc_system_pio_in_edge #(
   parameter int WIDTH     = 19,
   parameter int DEBOUNCE  = 0,
   parameter int EDGE_MODE = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] sync1_reg;
   logic [WIDTH-1:0] sync2_reg;
   logic [WIDTH-1:0] filtered;
   logic [WIDTH-1:0] prev_reg;
   logic [WIDTH-1:0] edgecap_reg;
   logic [WIDTH-1:0] edgecap_next;
   logic [WIDTH-1:0] irqmask_reg;
   logic [1:0]       ctrl_reg;
   logic [31:0]      readdata_reg;
   logic [31:0]      readdata_next;
   logic             irq_reg;
   logic             irq_next;

   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] hit;
   logic [WIDTH-1:0] w1c_mask;

   logic             wr_en;
   logic             wr_ctrl;
   logic             wr_irqmask;
   logic             wr_edgecap;
   logic             unused_bits;

   assign wr_en      = chipselect & ~write_n;
   assign wr_ctrl    = wr_en && (address == 2'd1);
   assign wr_irqmask = wr_en && (address == 2'd2);
   assign wr_edgecap = wr_en && (address == 2'd3);

   // Only the low bits of the write bus carry meaning; fold the rest away.
   assign unused_bits = ^writedata;

   // Two-flop synchroniser for the asynchronous inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= in_port;
         sync2_reg <= sync1_reg;
      end
   end

   generate
      if (DEBOUNCE == 0) begin : g_bypass
         logic [WIDTH-1:0] filt_reg;

         // Filter bypassed: filtered value simply follows the synchroniser.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               filt_reg <= '0;
            end else begin
               filt_reg <= sync2_reg;
            end
         end

         assign filtered = filt_reg;
      end else begin : g_debounce
         localparam int CW = $clog2(DEBOUNCE + 1);
         localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

         for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CW-1:0] cnt_reg;
            logic          filt_reg;

            // Count consecutive cycles of disagreement; accept the new level
            // only after it has held for DEBOUNCE cycles in a row.
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  cnt_reg  <= '0;
                  filt_reg <= 1'b0;
               end else if (sync2_reg[gi] == filt_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CNT_LAST) begin
                  filt_reg <= sync2_reg[gi];
                  cnt_reg  <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            assign filtered[gi] = filt_reg;
         end
      end
   endgenerate

   // Edge classification against the previous filtered sample.
   always_comb begin
      rise = filtered & ~prev_reg;
      fall = ~filtered & prev_reg;
      hit  = '0;
      case (ctrl_reg)
         2'd0:    hit = rise;
         2'd1:    hit = fall;
         2'd2:    hit = rise | fall;
         default: hit = '0;
      endcase
   end

   // Capture update: W1C clears first, a simultaneous hit re-sets the bit.
   always_comb begin
      w1c_mask     = wr_edgecap ? writedata[WIDTH-1:0] : '0;
      edgecap_next = (edgecap_reg & ~w1c_mask) | hit;
      irq_next     = |(edgecap_reg & irqmask_reg);
   end

   // Read mux, zero-extended; always active regardless of chipselect.
   always_comb begin
      readdata_next = '0;
      case (address)
         2'd0:    readdata_next[WIDTH-1:0] = filtered;
         2'd1:    readdata_next[1:0]       = ctrl_reg;
         2'd2:    readdata_next[WIDTH-1:0] = irqmask_reg;
         default: readdata_next[WIDTH-1:0] = edgecap_reg;
      endcase
   end

   // Edge history, control/mask/capture registers, registered read and irq.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_reg     <= '0;
         edgecap_reg  <= '0;
         irqmask_reg  <= '0;
         ctrl_reg     <= 2'(EDGE_MODE);
         readdata_reg <= '0;
         irq_reg      <= 1'b0;
      end else begin
         prev_reg     <= filtered;
         edgecap_reg  <= edgecap_next;
         readdata_reg <= readdata_next;
         irq_reg      <= irq_next;
         if (wr_ctrl) begin
            ctrl_reg <= writedata[1:0];
         end
         if (wr_irqmask) begin
            irqmask_reg <= writedata[WIDTH-1:0];
         end
      end
   end

   assign readdata = readdata_reg;
   assign irq      = irq_reg;

endmodule

// File: tb/tb_soc_system_pio_in_edge.sv
// Directed bench for soc_system_pio_in_edge: three instances cover the
// bypass filter (WIDTH 19), a 4-cycle debounce, and an 8-bit any-edge variant.
module tb_soc_system_pio_in_edge;

   logic        clk = 1'b0;
   logic [1:0]  address;
   logic        write_n;
   logic [31:0] writedata;
   logic [2:0]  cs;
   logic [2:0]  rst_n;
   logic [18:0] in0;
   logic [18:0] in1;
   logic [7:0]  in2;
   logic [31:0] rd0;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic        irq0;
   logic        irq1;
   logic        irq2;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       tag;
      int          inst;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   soc_system_pio_in_edge #(.WIDTH(19), .DEBOUNCE(0), .EDGE_MODE(0)) dut0 (
      .clk(clk), .reset_n(rst_n[0]), .address(address), .chipselect(cs[0]),
      .write_n(write_n), .writedata(writedata), .readdata(rd0),
      .in_port(in0), .irq(irq0)
   );

   soc_system_pio_in_edge #(.WIDTH(19), .DEBOUNCE(4), .EDGE_MODE(0)) dut1 (
      .clk(clk), .reset_n(rst_n[1]), .address(address), .chipselect(cs[1]),
      .write_n(write_n), .writedata(writedata), .readdata(rd1),
      .in_port(in1), .irq(irq1)
   );

   soc_system_pio_in_edge #(.WIDTH(8), .DEBOUNCE(4), .EDGE_MODE(2)) dut2 (
      .clk(clk), .reset_n(rst_n[2]), .address(address), .chipselect(cs[2]),
      .write_n(write_n), .writedata(writedata), .readdata(rd2),
      .in_port(in2), .irq(irq2)
   );

   function automatic logic [31:0] rd_of(int inst);
      case (inst)
         0:       return rd0;
         1:       return rd1;
         default: return rd2;
      endcase
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ticks(int n);
      repeat (n) tick();
   endtask

   task automatic wr(int inst, logic [1:0] a, logic [31:0] d);
      cs[inst]  = 1'b1;
      write_n   = 1'b0;
      address   = a;
      writedata = d;
      tick();
      cs        = '0;
      write_n   = 1'b1;
      writedata = '0;
      $display("wr dut%0d addr=%0d data=0x%08h", inst, a, d);
   endtask

   // Push the expectation when the read is issued, pop it when readdata is valid.
   task automatic rd(int inst, logic [1:0] a, logic [31:0] exp, string tag);
      exp_t e;
      address = a;
      e.tag   = tag;
      e.inst  = inst;
      e.exp   = exp;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      $display("rd dut%0d addr=%0d data=0x%08h (%s)", e.inst, a, rd_of(e.inst), e.tag);
      check(e.tag, rd_of(e.inst), e.exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;
      int lat;

      rst_n     = '0;
      cs        = '0;
      write_n   = 1'b1;
      address   = 2'd0;
      writedata = '0;
      in0       = '0;
      in1       = '0;
      in2       = '0;
      @(negedge clk);
      ticks(3);

      // Reset state while reset is held.
      check("rst_rd0", rd0, 32'h0);
      check("rst_irq0", {31'b0, irq0}, 32'h0);
      check("rst_rd1", rd1, 32'h0);
      check("rst_rd2", rd2, 32'h0);
      check("rst_irq2", {31'b0, irq2}, 32'h0);
      rst_n = '1;
      tick();
      rd(0, 2'd1, 32'h0, "ctrl_rst_mode0");
      rd(2, 2'd1, 32'h2, "ctrl_rst_mode2");
      rd(0, 2'd2, 32'h0, "irqmask_rst");
      rd(0, 2'd3, 32'h0, "edgecap_rst");

      // Bypass filter, rising capture on bit 3.
      wr(0, 2'd2, 32'h8);
      address = 2'd0;
      in0[3]  = 1'b1;
      found   = 1'b0;
      lat     = 0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (rd0 === 32'h8) begin
            found = 1'b1;
            lat   = k;
            break;
         end
      end
      check("data_bit3_in_time", {31'b0, (found && lat <= 4)}, 32'h1);
      check("irq_lags_capture", {31'b0, irq0}, 32'h0);
      tick();
      check("irq_after_capture", {31'b0, irq0}, 32'h1);
      rd(0, 2'd0, 32'h8, "data_bit3");
      rd(0, 2'd3, 32'h8, "edgecap_bit3");
      wr(0, 2'd3, 32'h8);
      check("irq_holds_during_w1c", {31'b0, irq0}, 32'h1);
      rd(0, 2'd3, 32'h0, "edgecap_w1c");
      check("irq_after_w1c", {31'b0, irq0}, 32'h0);

      // Same-cycle write and read of IRQMASK returns the old value.
      wr(0, 2'd2, 32'h2);
      check("rw_same_cycle_old", rd0, 32'h8);
      tick();
      check("rw_next_cycle_new", rd0, 32'h2);

      // Collision: W1C of bit 1 lands on the cycle a new rise is detected.
      in0[1] = 1'b1;
      ticks(6);
      rd(0, 2'd3, 32'h2, "bit1_first_rise");
      check("irq_bit1", {31'b0, irq0}, 32'h1);
      in0[1] = 1'b0;
      ticks(6);
      rd(0, 2'd3, 32'h2, "fall_ignored_mode0");
      in0[1] = 1'b1;
      ticks(3);
      wr(0, 2'd3, 32'h2);
      check("irq_collision", {31'b0, irq0}, 32'h1);
      rd(0, 2'd3, 32'h2, "collision_set_wins");
      check("irq_collision_hold", {31'b0, irq0}, 32'h1);
      wr(0, 2'd3, 32'h2);
      rd(0, 2'd3, 32'h0, "w1c_bit1_clear");

      // Mode 2 (any edge) on bit 5; upper CTRL bits are ignored.
      wr(0, 2'd1, 32'hFFFF_FFFE);
      rd(0, 2'd1, 32'h2, "ctrl_upper_ignored");
      in0[5] = 1'b1;
      ticks(6);
      rd(0, 2'd3, 32'h20, "mode2_rise");
      wr(0, 2'd3, 32'h20);
      rd(0, 2'd3, 32'h0, "mode2_w1c");
      in0[5] = 1'b0;
      ticks(6);
      rd(0, 2'd3, 32'h20, "mode2_fall");
      wr(0, 2'd3, 32'h20);

      // Mode 1 (falling only).
      wr(0, 2'd1, 32'h1);
      in0[5] = 1'b1;
      ticks(6);
      rd(0, 2'd3, 32'h0, "mode1_rise_ignored");
      in0[5] = 1'b0;
      ticks(6);
      rd(0, 2'd3, 32'h20, "mode1_fall");

      // Mode 3 (capture off); switching mode leaves captured bits alone.
      wr(0, 2'd1, 32'h3);
      rd(0, 2'd3, 32'h20, "mode_change_keeps_cap");
      wr(0, 2'd3, 32'h20);
      in0[5] = 1'b1;
      ticks(6);
      rd(0, 2'd3, 32'h0, "mode3_rise_off");
      in0[5] = 1'b0;
      ticks(6);
      rd(0, 2'd3, 32'h0, "mode3_fall_off");
      wr(0, 2'd1, 32'h0);

      // Debounce of 4: a 3-cycle glitch never appears.
      address = 2'd0;
      in1[0]  = 1'b1;
      ticks(3);
      in1[0]  = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         check("glitch_data", rd1, 32'h0);
      end
      rd(1, 2'd3, 32'h0, "glitch_no_capture");

      // A 4-cycle pulse passes the filter.
      address = 2'd0;
      in1[0]  = 1'b1;
      ticks(4);
      in1[0]  = 1'b0;
      found   = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (rd1[0] === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      check("debounce_pass", {31'b0, found}, 32'h1);
      rd(1, 2'd3, 32'h1, "debounce_capture");

      // WIDTH 8 instance: mask width, read-only DATA, async reset mid-activity.
      wr(2, 2'd2, 32'hFFFF_FFFF);
      rd(2, 2'd2, 32'h0000_00FF, "irqmask_width8");
      wr(2, 2'd0, 32'h55);
      rd(2, 2'd0, 32'h0, "data_read_only");
      in2[7] = 1'b1;
      ticks(10);
      rd(2, 2'd3, 32'h80, "w8_capture");
      check("w8_irq", {31'b0, irq2}, 32'h1);
      in2[0] = 1'b1;
      ticks(3);
      #2;
      rst_n[2] = 1'b0;
      #1;
      check("async_rst_rd", rd2, 32'h0);
      check("async_rst_irq", {31'b0, irq2}, 32'h0);
      in2 = '0;
      @(negedge clk);
      tick();
      rst_n[2] = 1'b1;
      ticks(2);
      rd(2, 2'd1, 32'h2, "post_rst_ctrl");
      rd(2, 2'd2, 32'h0, "post_rst_irqmask");
      ticks(8);
      rd(2, 2'd3, 32'h0, "post_rst_edgecap");
      rd(2, 2'd0, 32'h0, "post_rst_data");
      check("post_rst_irq", {31'b0, irq2}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
